// File: rtl/i2c_slave_ctrl_if.sv
// Signal bundle between the I2C responder and its surroundings: open-drain bus levels and
// pull-low enables, plus the local byte handshake (rx_data/rx_valid, tx_data/tx_req/tx_ready, busy).
interface i2c_slave_ctrl_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic       scl_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       tx_ready;
    logic       busy;

    modport slave (
        input  scl_in, sda_in, tx_data, tx_ready,
        output sda_oe, scl_oe, rx_data, rx_valid, tx_req, busy
    );

    modport master (
        output scl_in, sda_in, tx_data, tx_ready,
        input  sda_oe, scl_oe, rx_data, rx_valid, tx_req, busy
    );
endinterface

// File: rtl/i2c_slave_ctrl.sv
// I2C responder: oversampled SCL/SDA, START/STOP detection, 7-bit address match, byte write and read.
// Define SCL_STRETCH_EN to hold SCL low on a read while tx_ready is low; otherwise scl_oe is tied 0.
module i2c_slave_ctrl #(
    parameter logic [6:0] SLAVE_ADDR  = 7'b001_0000,
    parameter int         SYNC_STAGES = 2
) (
    input logic             clk,
    input logic             rst_n,
    i2c_slave_ctrl_if.slave bus
);
    localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_ADDR_ACK = 3'd2;
    localparam logic [2:0] S_WR_DATA  = 3'd3;
    localparam logic [2:0] S_WR_ACK   = 3'd4;
    localparam logic [2:0] S_RD_DATA  = 3'd5;
    localparam logic [2:0] S_RD_ACK   = 3'd6;
    localparam logic [2:0] S_IGNORE   = 3'd7;

    logic [NSYNC-1:0] scl_sync_q, scl_sync_d;
    logic [NSYNC-1:0] sda_sync_q, sda_sync_d;
    logic             scl_prev_q, scl_prev_d;
    logic             sda_prev_q, sda_prev_d;

    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;

    logic [2:0] state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       fetch_tx, load_tx;

`ifdef SCL_STRETCH_EN
    logic       scl_oe_q, scl_oe_d;
    logic       wait_q, wait_d;
    logic       rel_q, rel_d;
`endif

    // Synchronizers preset high so the idle bus shows no edge when reset is released.
    always_comb begin
        scl_sync_d = {scl_sync_q[NSYNC-2:0], bus.scl_in};
        sda_sync_d = {sda_sync_q[NSYNC-2:0], bus.sda_in};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_s     = scl_sync_q[NSYNC-1];
    assign sda_s     = sda_sync_q[NSYNC-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_shift_d = tx_shift_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        fetch_tx   = 1'b0;
        load_tx    = 1'b0;
`ifdef SCL_STRETCH_EN
        scl_oe_d   = rel_q ? 1'b0 : scl_oe_q;
        wait_d     = wait_q;
        rel_d      = 1'b0;
`endif

        if (stop_det) begin
            state_d   = S_IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
`ifdef SCL_STRETCH_EN
            wait_d    = 1'b0;
            scl_oe_d  = 1'b0;
`endif
        end else if (start_det) begin
            state_d   = S_ADDR;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
`ifdef SCL_STRETCH_EN
            wait_d    = 1'b0;
            scl_oe_d  = 1'b0;
`endif
        end
`ifdef SCL_STRETCH_EN
        else if (wait_q) begin
            if (bus.tx_ready) begin
                load_tx = 1'b1;
                wait_d  = 1'b0;
                rel_d   = 1'b1;
            end
        end
`endif
        else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (shift_d[7:1] == SLAVE_ADDR) begin
                                state_d  = S_ADDR_ACK;
                                busy_d   = 1'b1;
                                rw_d     = shift_d[0];
                                tx_req_d = shift_d[0];
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                // First fall drives the ACK, second fall ends the 9th clock.
                S_ADDR_ACK, S_WR_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_oe_d  = 1'b1;
                            bit_cnt_d = 4'd1;
                        end else if (state_q == S_ADDR_ACK && rw_q) begin
                            fetch_tx = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = S_WR_DATA;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        if (bit_cnt_q == 4'd7) begin
                            rx_data_d  = shift_d;
                            rx_valid_d = 1'b1;
                            bit_cnt_d  = 4'd0;
                            state_d    = S_WR_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                // bit_cnt counts bits already placed on the bus; the MSB went out at load time.
                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = S_RD_ACK;
                        end else begin
                            sda_oe_d   = ~tx_shift_q[7];
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                            bit_cnt_d  = bit_cnt_q + 4'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise && bit_cnt_q == 4'd0) begin
                        if (!sda_s) begin
                            tx_req_d  = 1'b1;
                            bit_cnt_d = 4'd1;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        fetch_tx = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (fetch_tx) begin
`ifdef SCL_STRETCH_EN
            if (bus.tx_ready) begin
                load_tx = 1'b1;
            end else begin
                wait_d   = 1'b1;
                scl_oe_d = 1'b1;
            end
`else
            load_tx = 1'b1;
`endif
        end

        if (load_tx) begin
            tx_shift_d = {bus.tx_data[6:0], 1'b0};
            sda_oe_d   = ~bus.tx_data[7];
            bit_cnt_d  = 4'd1;
            state_d    = S_RD_DATA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            tx_shift_q <= 8'd0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_shift_q <= tx_shift_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
        end
    end

`ifdef SCL_STRETCH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_oe_q <= 1'b0;
            wait_q   <= 1'b0;
            rel_q    <= 1'b0;
        end else begin
            scl_oe_q <= scl_oe_d;
            wait_q   <= wait_d;
            rel_q    <= rel_d;
        end
    end

    assign bus.scl_oe = scl_oe_q;
`else
    logic unused_tx_ready;
    assign unused_tx_ready = bus.tx_ready;
    assign bus.scl_oe      = 1'b0;
`endif

    assign bus.sda_oe   = sda_oe_q;
    assign bus.busy     = busy_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_req   = tx_req_q;
endmodule
